// File: rtl/reg_wr_arbiter_pkg.sv
// Shared definitions for the register write arbiter: FSM state encoding
// and the round-robin pointer advance used after each completed write.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } arb_state_e;

    // Index of the requester that follows idx in a ring of nreq requesters.
    function automatic int rr_next(input int idx, input int nreq);
        return (idx + 1 >= nreq) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Requester-side bus of the register write arbiter. The optional lock
// vector exists only when REG_ARB_LOCK_EN is defined.
interface reg_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
`ifdef REG_ARB_LOCK_EN
    logic [NREQ-1:0]       lock;
`endif
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  reg_load;
    logic [WIDTH-1:0]      reg_data;
    logic                  busy;

    // Requesting blocks.
    modport master (
        output req,
        output req_data,
`ifdef REG_ARB_LOCK_EN
        output lock,
`endif
        input  gnt,
        input  ack,
        input  reg_load,
        input  reg_data,
        input  busy
    );

    // The arbiter itself.
    modport slave (
        input  req,
        input  req_data,
`ifdef REG_ARB_LOCK_EN
        input  lock,
`endif
        output gnt,
        output ack,
        output reg_load,
        output reg_data,
        output busy
    );

endinterface

// File: rtl/reg_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first set request bit
// searching upward from rr_ptr_i with wrap-around.
module rr_picker #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    int cand;

    // Scan from the farthest position back to rr_ptr so the closest hit wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr_i) + k) % NREQ;
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin write arbiter sharing one loadable register among NREQ
// requesters. Each grant runs IDLE -> LOAD -> ACK with registered outputs.
// Optional macro REG_ARB_LOCK_EN adds a per-requester lock that chains
// back-to-back writes for the current owner without advancing rr_ptr.
import reg_arb_pkg::*;

module reg_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic             clk,
    input  logic             rst,
    reg_wr_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NREQ);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             relock;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx)
    );

`ifdef REG_ARB_LOCK_EN
    assign relock = bus.lock[gidx_q] && bus.req[gidx_q];
`else
    assign relock = 1'b0;
`endif

    // Next-state, grant bookkeeping and output values for the following cycle.
    always_comb begin
        state_d  = state_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        load_d   = 1'b0;
        data_d   = data_q;
        unique case (state_q)
            IDLE: begin
                gnt_d  = '0;
                data_d = '0;
                if (pick_valid) begin
                    gidx_d           = pick_idx;
                    gnt_d[pick_idx]  = 1'b1;
                    data_d           = bus.req_data[int'(pick_idx)*WIDTH +: WIDTH];
                    load_d           = 1'b1;
                    state_d          = LOAD;
                end
            end
            LOAD: begin
                ack_d[gidx_q] = 1'b1;
                state_d       = ACK;
            end
            ACK: begin
                if (relock) begin
                    data_d  = bus.req_data[int'(gidx_q)*WIDTH +: WIDTH];
                    load_d  = 1'b1;
                    state_d = LOAD;
                end else begin
                    rr_ptr_d = IDX_W'(rr_next(int'(gidx_q), NREQ));
                    gnt_d    = '0;
                    data_d   = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                data_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            load_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge inputs regardless of statement order.
            state_q  <= state_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            load_q   <= load_d;
            data_q   <= data_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.reg_load = load_q;
    assign bus.reg_data = data_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_reg_wr_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic [W-1:0] tb_reg = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: phase 0 = free, 1 = writing, 2 = acknowledging.
    int           m_phase;
    int           m_g;
    int           m_ptr;
    logic [W-1:0] m_d;
    logic [W-1:0] m_reg = '0;

    int           ack_cyc[$];
    int           ack_idx[$];
    logic [W-1:0] ack_val[$];

    reg_wr_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

    reg_wr_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // The shared register the arbiter writes.
    always_ff @(posedge clk) begin
        if (bus.reg_load) tb_reg <= bus.reg_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] dut_pack();
        return {14'd0, bus.gnt, bus.ack, bus.reg_load, bus.busy, bus.reg_data};
    endfunction

    function automatic logic [31:0] model_pack();
        logic [N-1:0] g1;
        g1 = N'(1) << m_g;
        return {14'd0,
                (m_phase != 0) ? g1 : {N{1'b0}},
                (m_phase == 2) ? g1 : {N{1'b0}},
                m_phase == 1,
                m_phase != 0,
                (m_phase != 0) ? m_d : {W{1'b0}}};
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_g     = 0;
        m_ptr   = 0;
        m_d     = '0;
    endtask

    // Advance the model by one cycle using the inputs that were present.
    task automatic model_step();
        logic lk;
`ifdef REG_ARB_LOCK_EN
        lk = bus.lock[m_g] && bus.req[m_g];
`else
        lk = 1'b0;
`endif
        case (m_phase)
            0: if (bus.req != '0) begin
                m_g     = pick(bus.req, m_ptr);
                m_d     = bus.req_data[m_g*W +: W];
                m_phase = 1;
            end
            1: begin
                m_reg   = m_d;
                m_phase = 2;
            end
            default: begin
                if (lk) begin
                    m_d     = bus.req_data[m_g*W +: W];
                    m_phase = 1;
                end else begin
                    m_ptr   = (m_g + 1) % N;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    // One clock: sample just after the edge, compare, leave inputs for caller.
    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check("outs", dut_pack(), model_pack());
        check("reg", 32'(tb_reg), 32'(m_reg));
    endtask

    initial begin
        logic [5:0] load_bits;
        logic       gnt2_held;
        logic       ack1_seen;

        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
`ifdef REG_ARB_LOCK_EN
        bus.lock     = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", dut_pack(), 32'd0);
        rst = 1'b0;

        // Fairness: all four requesting with distinct data.
        bus.req      = 4'b1111;
        bus.req_data = 32'h44332211;
        for (int c = 1; c <= 14; c++) begin
            cycle();
            if (bus.ack != '0) begin
                ack_cyc.push_back(c);
                ack_idx.push_back(onehot_idx(bus.ack));
                ack_val.push_back(tb_reg);
            end
        end
        bus.req = '0;
        cycle();
        check("fair_count", 32'(ack_idx.size()), 32'd5);
        if (ack_cyc.size() > 0) check("fair_first", 32'(ack_cyc[0]), 32'd2);
        for (int i = 0; i < ack_idx.size() && i < 5; i++) begin
            check("fair_order", 32'(ack_idx[i]), 32'(i % N));
            check("fair_data", 32'(ack_val[i]), 32'(((i % N) + 1) * 17));
            if (i > 0) check("fair_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end

        // Single write from requester 0.
        bus.req      = 4'b0001;
        bus.req_data = 32'h000000A5;
        cycle();
        check("sw_load", 32'(bus.reg_load), 32'd1);
        check("sw_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        cycle();
        check("sw_ack", 32'(bus.ack), 32'h1);
        check("sw_reg", 32'(tb_reg), 32'hA5);
        cycle();
        check("sw_idle", 32'(bus.busy), 32'd0);

        // Wrap-around: serve 2 so the pointer sits at 3, then 3 and 0 compete.
        bus.req      = 4'b0100;
        bus.req_data = 32'h00C30000;
        cycle();
        check("wrap_g2", 32'(bus.gnt), 32'h4);
        bus.req = '0;
        cycle();
        bus.req      = 4'b1001;
        bus.req_data = 32'hD00000E0;
        cycle();
        cycle();
        check("wrap_first", 32'(bus.gnt), 32'h8);
        cycle();
        check("wrap_ack3", 32'(bus.ack), 32'h8);
        check("wrap_reg3", 32'(tb_reg), 32'hD0);
        cycle();
        cycle();
        check("wrap_second", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        cycle();
        check("wrap_reg0", 32'(tb_reg), 32'hE0);
        cycle();

        // Withdraw: requester 1 drops req and changes data after the grant.
        bus.req      = 4'b0010;
        bus.req_data = 32'h00005A00;
        cycle();
        check("wd_gnt", 32'(bus.gnt), 32'h2);
        bus.req      = '0;
        bus.req_data = 32'h0000FF00;
        cycle();
        check("wd_ack", 32'(bus.ack), 32'h2);
        check("wd_reg", 32'(tb_reg), 32'h5A);
        cycle();

        // Asynchronous reset during LOAD.
        bus.req      = 4'b1000;
        bus.req_data = 32'h77000000;
        cycle();
        check("pre_rst_load", 32'(bus.reg_load), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("rst_async", dut_pack(), 32'd0);
        model_reset();
        bus.req = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_noreg", 32'(tb_reg), 32'(m_reg));

        // Pointer must be back at 0: requester 1 beats 2.
        bus.req      = 4'b0110;
        bus.req_data = 32'h00BBCC00;
        cycle();
        check("post_rst_ptr", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        cycle();
        cycle();
        bus.req = 4'b0100;
        cycle();
        check("post_rst_gnt2", 32'(bus.gnt), 32'h4);
        bus.req = '0;
        cycle();
        cycle();

`ifdef REG_ARB_LOCK_EN
        // Bring the pointer to 2, then lock requester 2 for three writes.
        bus.req = 4'b0010;
        cycle();
        bus.req = '0;
        cycle();
        cycle();
        bus.req      = 4'b0110;
        bus.lock     = 4'b0100;
        bus.req_data = 32'h00A0B000;
        load_bits = '0;
        gnt2_held = 1'b1;
        ack1_seen = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            cycle();
            load_bits[c-1] = bus.reg_load;
            gnt2_held      = gnt2_held & bus.gnt[2];
            ack1_seen      = ack1_seen | bus.ack[1];
            if (c == 5) bus.lock = '0;
        end
        check("lock_loads", 32'(load_bits), 32'b010101);
        check("lock_gnt2", 32'(gnt2_held), 32'd1);
        check("lock_no_ack1", 32'(ack1_seen), 32'd0);
        cycle();
        cycle();
        check("lock_next", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        cycle();
        cycle();
`else
        load_bits = '0;
        gnt2_held = 1'b0;
        ack1_seen = 1'b0;
`endif

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) != 0) bus.req = N'($urandom);
            bus.req_data = $urandom;
`ifdef REG_ARB_LOCK_EN
            bus.lock = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
`endif
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
